// File: rtl/data_ram_pkg.sv
// Shared defaults and FSM state type for the data RAM controller.
// DATA_RAM_INIT_PATTERN_EN enables the post-reset 2*i fill sweep.
package data_ram_pkg;

    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned DEPTH_DEF  = 64;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        IDLE = 1'b1
    } state_e;

endpackage

// File: rtl/data_ram_init_seq.sv
// Post-reset fill sequencer: walks addresses 0..DEPTH-1, one per cycle, writing 2*i.
// Only instantiated when DATA_RAM_INIT_PATTERN_EN is defined.
module data_ram_init_seq
    import data_ram_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n_i,
    input  logic              en_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              we_o,
    output logic              done_o
);

    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    always_comb begin
        done_o = en_i && (cnt_q == ADDR_W'(DEPTH - 1));
        cnt_d  = cnt_q;
        if (en_i) begin
            cnt_d = done_o ? '0 : cnt_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign addr_o = cnt_q;
    assign data_o = DATA_W'(32'(cnt_q) << 1);
    assign we_o   = en_i;

endmodule

// File: rtl/data_ram_ctrl.sv
// Register-file RAM with a shared tri-state CPU bus, zero-latency reads and a
// sticky read/write collision flag. DATA_RAM_INIT_PATTERN_EN adds the INIT fill sweep.
module data_ram_ctrl
    import data_ram_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address_to_ram,
    input  logic              write_enable_to_ram,
    input  logic              read_enable_to_ram,
    inout  wire  [DATA_W-1:0] data_ram,
    output logic              ram_ready,
    output logic              collision_err
);

    logic [1:0]        rst_sync_q;
    logic              rst_int_n;
    state_e            state_q;
    state_e            state_d;
    logic              coll_q;
    logic              coll_d;
    logic [ADDR_W-1:0] idx;
    logic              serve_wr;
    logic              serve_rd;
    logic              req_coll;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Assert immediately, release two clean edges after reset goes high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_int_n = rst_sync_q[1];

    assign idx       = ADDR_W'(32'(address_to_ram) % DEPTH);
    assign ram_ready = (state_q == IDLE) && rst_int_n;
    assign req_coll  = ram_ready && write_enable_to_ram && read_enable_to_ram;
    assign serve_wr  = ram_ready && write_enable_to_ram && !read_enable_to_ram;
    assign serve_rd  = ram_ready && read_enable_to_ram && !write_enable_to_ram;
    assign coll_d    = coll_q || req_coll;

`ifdef DATA_RAM_INIT_PATTERN_EN
    localparam state_e RST_STATE = INIT;

    logic [ADDR_W-1:0] init_addr;
    logic [DATA_W-1:0] init_data;
    logic              init_we;
    logic              init_done;

    data_ram_init_seq #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_init_seq (
        .clk     (clk),
        .rst_n_i (rst_int_n),
        .en_i    ((state_q == INIT) && rst_int_n),
        .addr_o  (init_addr),
        .data_o  (init_data),
        .we_o    (init_we),
        .done_o  (init_done)
    );

    always_comb begin
        state_d = state_q;
        if ((state_q == INIT) && init_done) begin
            state_d = IDLE;
        end
        mem_we    = init_we || serve_wr;
        mem_waddr = init_we ? init_addr : idx;
        mem_wdata = init_we ? init_data : data_ram;
    end
`else
    localparam state_e RST_STATE = IDLE;

    always_comb begin
        state_d   = IDLE;
        mem_we    = serve_wr;
        mem_waddr = idx;
        mem_wdata = data_ram;
    end
`endif

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= RST_STATE;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            coll_q  <= coll_d;
        end
    end

    // Storage has no reset; only the INIT sweep clears it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign data_ram      = serve_rd ? mem_q[idx] : 'z;
    assign collision_err = coll_q;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Self-checking bench for data_ram_ctrl: vector table, random ops against an
// array model, and reset / INIT corner sequences (DATA_RAM_INIT_PATTERN_EN aware).
module tb_data_ram_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  addr;
    logic        we;
    logic        re;
    logic [15:0] tb_bus;
    logic        tb_drv;
    wire  [15:0] data_ram;
    logic        ram_ready;
    logic        collision_err;

    int tests = 0;
    int fails = 0;

    logic [15:0] ref_mem [64];
    bit          ref_val [64];
    bit          ref_coll;

    typedef struct {
        bit          we;
        bit          re;
        logic [5:0]  addr;
        logic [15:0] data;
        bit          chk_rd;
        logic [15:0] exp_rd;
        bit          exp_coll;
    } vec_t;

    vec_t vecs [13];

    assign data_ram = tb_drv ? tb_bus : 'z;

    always #5 clk = ~clk;

    data_ram_ctrl #(
        .ADDR_W (6),
        .DATA_W (16),
        .DEPTH  (64)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .address_to_ram      (addr),
        .write_enable_to_ram (we),
        .read_enable_to_ram  (re),
        .data_ram            (data_ram),
        .ram_ready           (ram_ready),
        .collision_err       (collision_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic set_idle();
        we     = 1'b0;
        re     = 1'b0;
        tb_drv = 1'b0;
        tb_bus = '0;
    endtask

    // One bus cycle checked against the array model; the bench drives 0 when
    // nothing else should be on the bus, so any DUT drive shows up.
    task automatic op(input bit w, input bit r, input logic [5:0] a, input logic [15:0] d);
        @(negedge clk);
        we     = w;
        re     = r;
        addr   = a;
        tb_bus = w ? d : 16'h0000;
        tb_drv = w || !r;
        #1;
        if (r && !w) begin
            if (ref_val[a]) chk("read_data", 32'(data_ram), 32'(ref_mem[a]));
        end else begin
            chk("bus_not_driven", 32'(data_ram), 32'(tb_bus));
        end
        chk("ready_idle", 32'(ram_ready), 32'd1);
        @(posedge clk);
        #1;
        if (w && !r) begin
            ref_mem[a] = d;
            ref_val[a] = 1'b1;
        end
        if (w && r) ref_coll = 1'b1;
        chk("collision_flag", 32'(collision_err), 32'(ref_coll));
    endtask

    // Hold reset with write/read requests pending; none may take effect.
    task automatic hold_reset();
        @(negedge clk);
        reset  = 1'b0;
        we     = 1'b1;
        re     = 1'b0;
        addr   = 6'd8;
        tb_bus = 16'hFFFF;
        tb_drv = 1'b1;
        repeat (2) @(negedge clk);
        we     = 1'b0;
        re     = 1'b1;
        addr   = 6'd16;
        tb_bus = 16'h0000;
        #1;
        chk("reset_bus_not_driven", 32'(data_ram), 32'h0);
        chk("reset_ready", 32'(ram_ready), 32'd0);
        chk("reset_collision", 32'(collision_err), 32'd0);
        @(negedge clk);
        set_idle();
        ref_coll = 1'b0;
    endtask

    task automatic release_and_wait(input int lo, input int hi, input bit poke);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            n = i;
            #1;
            if (ram_ready) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            if (poke && n >= 40 && n < 46) begin
                we = 1'b1; re = 1'b0; addr = 6'd8; tb_bus = 16'hFFFF; tb_drv = 1'b1;
            end else if (poke && n >= 46 && n < 50) begin
                we = 1'b0; re = 1'b1; addr = 6'd5; tb_bus = 16'h0000; tb_drv = 1'b1;
                #1;
                chk("init_bus_not_driven", 32'(data_ram), 32'h0);
            end else begin
                set_idle();
            end
        end
        tests++;
        if (!seen || n < lo || n > hi) begin
            fails++;
            $display("FAIL ready_latency: got %0d edges (seen=%0d), required %0d..%0d", n, seen, lo, hi);
        end
        @(negedge clk);
        set_idle();
    endtask

    task automatic read_all();
        for (int i = 0; i < 64; i++) op(1'b0, 1'b1, 6'(i), 16'h0);
    endtask

    task automatic set_init_model();
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = 16'(2 * i);
            ref_val[i] = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 6'd17, 16'h0022, 1'b0, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 6'd16, 16'hBEEF, 1'b0, 16'h0000, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 6'd16, 16'h0000, 1'b1, 16'hBEEF, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 6'd17, 16'h0000, 1'b1, 16'h0022, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 6'd3,  16'h5A5A, 1'b0, 16'h0000, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 6'd3,  16'h0000, 1'b1, 16'h5A5A, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 6'd3,  16'h1234, 1'b1, 16'h1234, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 6'd3,  16'h0000, 1'b1, 16'h5A5A, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 6'd63, 16'h8001, 1'b0, 16'h0000, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 6'd63, 16'h0000, 1'b1, 16'h8001, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 6'd0,  16'h7FFE, 1'b0, 16'h0000, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 6'd0,  16'h0000, 1'b1, 16'h7FFE, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 6'd63, 16'h0000, 1'b1, 16'h8001, 1'b1};

        for (int i = 0; i < 64; i++) ref_val[i] = 1'b0;
        ref_coll = 1'b0;
        reset    = 1'b1;
        addr     = '0;
        set_idle();
        #2;
        reset = 1'b0;

        hold_reset();
`ifdef DATA_RAM_INIT_PATTERN_EN
        release_and_wait(64, 67, 1'b0);
        set_init_model();
        op(1'b0, 1'b1, 6'd0, 16'h0);
        op(1'b0, 1'b1, 6'd5, 16'h0);
        op(1'b0, 1'b1, 6'd63, 16'h0);
`else
        release_and_wait(1, 3, 1'b0);
`endif

        foreach (vecs[k]) begin
            @(negedge clk);
            we     = vecs[k].we;
            re     = vecs[k].re;
            addr   = vecs[k].addr;
            tb_bus = vecs[k].data;
            tb_drv = vecs[k].we;
            #1;
            if (vecs[k].chk_rd) chk($sformatf("vec%0d_bus", k), 32'(data_ram), 32'(vecs[k].exp_rd));
            chk($sformatf("vec%0d_ready", k), 32'(ram_ready), 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_collision", k), 32'(collision_err), 32'(vecs[k].exp_coll));
            if (vecs[k].we && !vecs[k].re) begin
                ref_mem[vecs[k].addr] = vecs[k].data;
                ref_val[vecs[k].addr] = 1'b1;
            end
            if (vecs[k].we && vecs[k].re) ref_coll = 1'b1;
        end

        for (int i = 0; i < 300; i++) begin
            logic [1:0] kind;
            kind = 2'($urandom_range(0, 3));
            op(kind == 2'd1 || kind == 2'd3 ? 1'b1 : 1'b0,
               kind == 2'd2 || kind == 2'd3 ? 1'b1 : 1'b0,
               6'($urandom_range(0, 63)), 16'($urandom));
        end
        chk("collision_sticky", 32'(collision_err), 32'd1);

        hold_reset();
`ifdef DATA_RAM_INIT_PATTERN_EN
        // Abort the sweep partway, then require a full fresh sweep.
        @(negedge clk);
        reset = 1'b1;
        repeat (22) @(posedge clk);
        #1;
        chk("mid_init_ready", 32'(ram_ready), 32'd0);
        hold_reset();
        release_and_wait(64, 67, 1'b1);
        set_init_model();
`else
        release_and_wait(1, 3, 1'b0);
`endif
        chk("collision_cleared", 32'(collision_err), 32'd0);
        read_all();

        @(negedge clk);
        set_idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
